seq_detector: RTL and testbench
===============================

# seq_detector

Parametrised serial bit-sequence detector: the next generation of the team's fixed-pattern D-flip-flop detector. It samples a serial input bit stream qualified by a valid strobe and compares the most recent `PAT_W` bits against a runtime-loadable pattern. It supports overlapping and non-overlapping match modes and emits a registered one-cycle match pulse. It sits directly on a serial data line in front of framing and control logic.

## Interface
- `PAT_W`, default 4: pattern length in bits; legal range 2..32.
- `CNT_W`, default 8: width of the match counter (used only with `SEQDET_MATCH_CNT_EN`).

Ports:
- `clk` input, 1: single clock; all logic on posedge.
- `rst_n` input, 1: reset, synchronous, active-low.
- `x` input, 1: serial data bit.
- `x_vld` input, 1: `x` is sampled only when high.
- `pattern` input, `PAT_W`: pattern to detect. MSB is the first bit received, LSB the last.
- `overlap` input, 1: mode, captured on `pat_load`. 1 = overlapping, 0 = non-overlapping.
- `pat_load` input, 1: one-cycle strobe. Captures `pattern` and `overlap`, clears history, arms the detector.
- `y` output, 1: registered match pulse.
- `match_cnt` output, `CNT_W`: saturating match count. Present only with `SEQDET_MATCH_CNT_EN`.

## Operation
- Internal state:
  - `pat_q`, `ovl_q`: captured pattern and mode.
  - `hist`: `PAT_W`-bit shift register; the newest bit enters at the LSB.
  - `fill`: bit counter, 0..`PAT_W`.
  - FSM: IDLE, FILL, HUNT.
- IDLE (after reset):
  - `x_vld` is ignored.
  - `pat_load` → FILL.
- FILL: on each `x_vld`, shift `x` into `hist` and increment `fill`. The bit that makes `fill` = `PAT_W` is compared immediately.
  - No match → HUNT.
  - Match with `ovl_q`=1 → HUNT.
  - Match with `ovl_q`=0 → stay in FILL with `fill`=0.
- HUNT: on each `x_vld`, shift `x` in and compare `{hist[PAT_W-2:0], x}` against `pat_q`.
  - Match with `ovl_q`=0 → FILL, `fill`=0, `hist` cleared.
  - Match with `ovl_q`=1 → stay in HUNT with history retained.
- Match condition:
  - Full `PAT_W`-bit equality, with at least `PAT_W` valid bits received since the last arm or non-overlap match.
  - Partial history never matches.
- `pat_load` from any non-reset state:
  - Recaptures `pat_q`/`ovl_q`, clears `hist` and `fill`, clears `match_cnt`, enters FILL.
  - Changes on `pattern`/`overlap` between loads have no effect.
- `pat_load` and `x_vld` in the same cycle: the load wins and the bit is discarded.
- `x_vld` low: no shift, no compare; `y` is 0 that cycle.
- Reset mid-operation:
  - All state cleared: `pat_q`=0, `ovl_q`=0, FSM→IDLE.
  - Any pending match is dropped.

## Timing
- Reset values: `y`=0, `match_cnt`=0, FSM=IDLE, `hist`=0, `fill`=0.
- Latency:
  - The completing bit is sampled at edge N.
  - `y` is high from edge N to edge N+1, exactly one cycle.
  - `y` is never asserted on two consecutive cycles unless `x_vld` is high on both and both bits complete matches (possible only in overlap mode).
- `match_cnt` updates at the same edge that asserts `y`.
- `pat_load` takes effect at its sampling edge. The first bit counted is the next `x_vld` cycle.
- No combinational path from any input to `y` or `match_cnt`.

## Configuration
- Macro: `SEQDET_MATCH_CNT_EN`.
- Defined:
  - `match_cnt` port and counter logic are present.
  - The counter increments by 1 per `y` pulse and saturates at 2^`CNT_W`−1.
  - It clears on reset and on `pat_load`.
- Undefined:
  - No `match_cnt` port and no counter logic.
  - All other behaviour is identical.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles, then drive `x_vld`=1 with `x`=1 for 6 cycles without `pat_load` → `y` stays 0, `match_cnt`=0.
- Overlap: `PAT_W`=4, load `pattern`=4'b1011, `overlap`=1, stream 1,0,1,1,0,1,1 → `y` pulses after bit 4 and bit 7; `match_cnt`=2.
- Non-overlap: same stream with `overlap`=0 → `y` pulses after bit 4 only; `match_cnt`=1.
- Valid gaps: pattern 1011, send 1,0, then `x_vld`=0 for 5 cycles, then 1,1 → one `y` pulse, one cycle after the final bit; `y`=0 throughout the gap.
- Load collision:
  - After bits 1,0,1, assert `pat_load` (pattern 1011) together with `x_vld`=1, `x`=1 → that bit is discarded, `fill` restarts.
  - A following 1,0,1,1 → exactly one `y` pulse.
- Saturation: `CNT_W`=2, 5 overlapping matches of pattern 4'b1111 → `match_cnt` reads 3 and holds; then `rst_n`=0 for 1 cycle → `match_cnt`=0, `y`=0.

Source files
------------

// File: rtl/seq_detector_if.sv
// Serial detector bus: stream bit, valid strobe, pattern-load controls and the match pulse.
interface seq_detector_if #(
  parameter int unsigned PAT_W = 4
);
  logic             x;
  logic             x_vld;
  logic [PAT_W-1:0] pattern;
  logic             overlap;
  logic             pat_load;
  logic             y;

  modport master (output x, x_vld, pattern, overlap, pat_load, input y);
  modport slave  (input x, x_vld, pattern, overlap, pat_load, output y);
endinterface

// File: rtl/seq_detector.sv
// Parametrised serial bit-sequence detector with overlap/non-overlap modes and a registered match pulse.
// Optional saturating match counter enabled by `define SEQDET_MATCH_CNT_EN.
module seq_detector #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  seq_detector_if.slave bus
`ifdef SEQDET_MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  if (PAT_W < 2 || PAT_W > 32 || CNT_W < 1) begin : g_bad_param
    $error("seq_detector: PAT_W must be 2..32 and CNT_W at least 1");
  end

  localparam int unsigned FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FILL_LAST = FW'(PAT_W - 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(PAT_W);

  typedef enum logic [1:0] {IDLE, FILL, HUNT} state_t;

  state_t           state;
  logic [PAT_W-1:0] pat_q;
  logic             ovl_q;
  logic [PAT_W-1:0] hist;
  logic [FW-1:0]    fill;
  logic [PAT_W-1:0] hist_nxt;
  logic             hit;

  // A compare only counts once PAT_W bits have arrived since the last arm.
  always_comb begin
    hist_nxt = {hist[PAT_W-2:0], bus.x};
    hit      = 1'b0;
    if (bus.x_vld && !bus.pat_load && (hist_nxt == pat_q))
      hit = (state == HUNT) || ((state == FILL) && (fill == FILL_LAST));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pat_q <= '0;
      ovl_q <= 1'b0;
      hist  <= '0;
      fill  <= '0;
      bus.y <= 1'b0;
    end else begin
      bus.y <= hit;
      if (bus.pat_load) begin
        pat_q <= bus.pattern;
        ovl_q <= bus.overlap;
        hist  <= '0;
        fill  <= '0;
        state <= FILL;
      end else if (bus.x_vld) begin
        case (state)
          FILL: begin
            if (fill == FILL_LAST) begin
              if (hit && !ovl_q) begin
                hist <= '0;
                fill <= '0;
              end else begin
                hist  <= hist_nxt;
                fill  <= FILL_FULL;
                state <= HUNT;
              end
            end else begin
              hist <= hist_nxt;
              fill <= fill + 1'b1;
            end
          end
          HUNT: begin
            if (hit && !ovl_q) begin
              hist  <= '0;
              fill  <= '0;
              state <= FILL;
            end else begin
              hist <= hist_nxt;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SEQDET_MATCH_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n || bus.pat_load)
      match_cnt <= '0;
    else if (hit && (match_cnt != '1))
      match_cnt <= match_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_seq_detector.sv
// Self-checking bench for seq_detector: directed scenarios plus random stream against a bit-queue model.
`timescale 1ns/1ps
module tb_seq_detector;

  localparam int unsigned PAT_W = 4;
  localparam int unsigned CNT_W = 2;

  logic clk;
  logic rst_n;

  seq_detector_if #(.PAT_W(PAT_W)) bus ();

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] match_cnt;
`endif

  seq_detector #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus)
`ifdef SEQDET_MATCH_CNT_EN
    ,
    .match_cnt (match_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model: bits received since last arm, captured pattern/mode, count.
  int unsigned      m_bits[$];
  logic             m_armed = 1'b0;
  logic [PAT_W-1:0] m_pat   = '0;
  logic             m_ovl   = 1'b0;
  int unsigned      m_cnt   = 0;
  logic             exp_y   = 1'b0;
  int unsigned      pulses  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input logic rst, input logic ld, input logic vld, input logic xb,
                       input logic [PAT_W-1:0] pat, input logic ovl);
    logic [PAT_W-1:0] last;
    rst_n        = ~rst;
    bus.pat_load = ld;
    bus.x_vld    = vld;
    bus.x        = xb;
    bus.pattern  = pat;
    bus.overlap  = ovl;
    exp_y = 1'b0;
    if (rst) begin
      m_armed = 1'b0; m_pat = '0; m_ovl = 1'b0; m_cnt = 0; m_bits.delete();
    end else if (ld) begin
      m_armed = 1'b1; m_pat = pat; m_ovl = ovl; m_cnt = 0; m_bits.delete();
    end else if (vld && m_armed) begin
      m_bits.push_back(int'(xb));
      if (m_bits.size() >= PAT_W) begin
        for (int i = 0; i < PAT_W; i++)
          last[i] = m_bits[m_bits.size() - 1 - i][0];
        if (last == m_pat) begin
          exp_y = 1'b1;
          if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
          if (!m_ovl) m_bits.delete();
        end
      end
      while (m_bits.size() > PAT_W) void'(m_bits.pop_front());
    end
    @(posedge clk);
    #1;
    chk("y", 32'(bus.y), 32'(exp_y));
    if (bus.y === 1'b1) pulses++;
`ifdef SEQDET_MATCH_CNT_EN
    chk("match_cnt", 32'(match_cnt), m_cnt);
`endif
  endtask

  task automatic send(input logic [PAT_W-1:0] pat, input logic ovl, input int unsigned n,
                      input logic [31:0] bits);
    for (int i = n - 1; i >= 0; i--) cycle(1'b0, 1'b0, 1'b1, bits[i], pat, ovl);
  endtask

  task automatic idle(input int unsigned n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    bus.x = 1'b0; bus.x_vld = 1'b0; bus.pattern = '0; bus.overlap = 1'b0; bus.pat_load = 1'b0;
    rst_n = 1'b0;

    // Reset, then unarmed stream of ones
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    pulses = 0;
    send('0, 1'b0, 6, 32'b111111);
    chk("unarmed_pulses", pulses, 0);

    // Overlap: 1011 in 1011011
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'b1011, 1'b1);
    pulses = 0;
    send(4'b1011, 1'b1, 7, 32'b1011011);
    chk("ovl_pulses", pulses, 2);

    // Non-overlap
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'b1011, 1'b0);
    pulses = 0;
    send(4'b1011, 1'b0, 7, 32'b1011011);
    chk("novl_pulses", pulses, 1);

    // Valid gaps
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'b1011, 1'b0);
    pulses = 0;
    send(4'b1011, 1'b0, 2, 32'b10);
    idle(5);
    chk("gap_pulses", pulses, 0);
    send(4'b1011, 1'b0, 2, 32'b11);
    chk("gap_done", pulses, 1);

    // Load collides with a valid bit: bit discarded
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'b1011, 1'b0);
    pulses = 0;
    send(4'b1011, 1'b0, 3, 32'b101);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'b1011, 1'b0);
    send(4'b1011, 1'b0, 4, 32'b1011);
    chk("collide_pulses", pulses, 1);

    // Counter saturation then reset
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'b1111, 1'b1);
    pulses = 0;
    send(4'b1111, 1'b1, 8, 32'hFF);
    chk("sat_pulses", pulses, 5);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b1);

    // Random stream
    for (int i = 0; i < 1500; i++) begin
      logic r_rst, r_ld, r_vld;
      r_rst = ($urandom_range(0, 59) == 0);
      r_ld  = ($urandom_range(0, 14) == 0);
      r_vld = ($urandom_range(0, 3) != 0);
      cycle(r_rst, r_ld, r_vld, 1'($urandom), PAT_W'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
